execute_stage_unit: RTL and testbench

- Execute stage of the 5-stage RV32IM pipeline; consumes the decode-to-execute pipeline register outputs directly.
- Performs single-cycle ALU, branch compare and target generation.
- Performs iterative 32-cycle RV32M multiply/divide; stalls the upstream pipeline while busy.
- Results feed the execute-to-memory pipeline register and the fetch PC mux.

---
 rtl/execute_stage_unit_if.sv | 38 +++
 rtl/execute_stage_unit.sv | 256 +++++++++++++++++++++++++
 tb/tb_execute_stage_unit.sv | 325 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/execute_stage_unit_if.sv
// Execute stage bus: groups every execute-stage signal except clock and reset.
//   Inputs to the stage : flush, pc, readData1, readData2, immediateValue,
//                         func3, func7, pcUpdate, aluSrc1, aluSrc2,
//                         aluOperation, pcAdderSrc
//   Outputs of the stage: aluResult, storeData, branchTarget, branchTaken, stall
// master = the pipeline side that drives the decoded instruction,
// slave  = the execute stage itself.
interface execute_stage_unit_if;
  logic        flush;
  logic [31:0] pc;
  logic [31:0] readData1;
  logic [31:0] readData2;
  logic [31:0] immediateValue;
  logic [2:0]  func3;
  logic [6:0]  func7;
  logic        pcUpdate;
  logic [1:0]  aluSrc1;
  logic [1:0]  aluSrc2;
  logic [2:0]  aluOperation;
  logic        pcAdderSrc;
  logic [31:0] aluResult;
  logic [31:0] storeData;
  logic [31:0] branchTarget;
  logic        branchTaken;
  logic        stall;

  modport master (
    output flush, pc, readData1, readData2, immediateValue, func3, func7,
           pcUpdate, aluSrc1, aluSrc2, aluOperation, pcAdderSrc,
    input  aluResult, storeData, branchTarget, branchTaken, stall
  );

  modport slave (
    input  flush, pc, readData1, readData2, immediateValue, func3, func7,
           pcUpdate, aluSrc1, aluSrc2, aluOperation, pcAdderSrc,
    output aluResult, storeData, branchTarget, branchTaken, stall
  );
endinterface

// File: rtl/execute_stage_unit.sv
// Execute stage of the RV32IM pipeline.
//   clock : rising-edge clock
//   reset : synchronous, active-high; forces every output to 0 while high
//   bus   : execute_stage_unit_if.slave carrying the decoded instruction
//           (operands, control) in and aluResult/storeData/branchTarget/
//           branchTaken/stall out.
// Plain ALU, branch compare and target generation are combinational. RV32M
// ops run on an iterative unit (32 shift-add or restoring-subtract steps on
// operand magnitudes, sign fixed up at the end) that stalls upstream while busy.
module execute_stage_unit #(
  parameter bit ENABLE_MULDIV    = 1'b1,
  parameter bit FAST_DIV_BY_ZERO = 1'b1
) (
  input logic                  clock,
  input logic                  reset,
  execute_stage_unit_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t      state;
  state_t      stateNext;
  logic [4:0]  counter;
  logic [2:0]  opFunc3;
  logic [31:0] operand;
  logic [31:0] accHi;
  logic [31:0] accLo;
  logic        signA;
  logic        signB;

  logic [31:0] src1;
  logic [31:0] src2;
  logic [4:0]  shamt;
  logic        altFunc;
  logic [31:0] aluValue;
  logic        branchCond;
  logic        isMOp;
  logic        issue;
  logic        signedA;
  logic        signedB;
  logic        negA;
  logic        negB;
  logic [31:0] absA;
  logic [31:0] absB;
  logic        divByZero;
  logic [32:0] mulSum;
  logic [32:0] divShifted;
  logic [32:0] divDiff;
  logic [63:0] product;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic [31:0] mulDivResult;

  // Operand multiplexers feeding the ALU and the branch comparator.
  always_comb begin
    src1 = '0;
    src2 = 32'd4;
    case (bus.aluSrc1)
      2'b00:   src1 = bus.readData1;
      2'b01:   src1 = bus.pc;
      default: src1 = '0;
    endcase
    case (bus.aluSrc2)
      2'b00:   src2 = bus.readData2;
      2'b01:   src2 = bus.immediateValue;
      default: src2 = 32'd4;
    endcase
  end

  assign shamt = src2[4:0];

  // Single-cycle ALU. func7[5] means SUB/SRA for R-type but only SRAI for
  // I-type, since an I-type ADDI carries immediate bits in that position.
  always_comb begin
    aluValue = src1 + src2;
    altFunc  = 1'b0;
    case (bus.aluOperation)
      3'b001, 3'b010: begin
        altFunc = bus.func7[5] &&
                  ((bus.aluOperation == 3'b001) || (bus.func3 == 3'b101));
        case (bus.func3)
          3'b000:  aluValue = altFunc ? (src1 - src2) : (src1 + src2);
          3'b001:  aluValue = src1 << shamt;
          3'b010:  aluValue = {31'b0, $signed(src1) < $signed(src2)};
          3'b011:  aluValue = {31'b0, src1 < src2};
          3'b100:  aluValue = src1 ^ src2;
          3'b101:  aluValue = altFunc ? $unsigned($signed(src1) >>> shamt)
                                      : (src1 >> shamt);
          3'b110:  aluValue = src1 | src2;
          default: aluValue = src1 & src2;
        endcase
      end
      3'b100:  aluValue = src2;
      default: aluValue = src1 + src2;
    endcase
  end

  // Conditional branch compare; the two reserved func3 codes never branch.
  always_comb begin
    branchCond = 1'b0;
    case (bus.func3)
      3'b000:  branchCond = (src1 == src2);
      3'b001:  branchCond = (src1 != src2);
      3'b100:  branchCond = ($signed(src1) <  $signed(src2));
      3'b101:  branchCond = ($signed(src1) >= $signed(src2));
      3'b110:  branchCond = (src1 <  src2);
      3'b111:  branchCond = (src1 >= src2);
      default: branchCond = 1'b0;
    endcase
  end

  assign isMOp = (bus.aluOperation == 3'b001) && (bus.func7 == 7'b0000001);
  assign issue = ENABLE_MULDIV && (state == IDLE) && isMOp && !bus.flush;

  // Operand signedness by M-op: MUL/MULH/DIV/REM are signed on both sides,
  // MULHSU only on rs1, the U variants on neither.
  always_comb begin
    signedA = 1'b0;
    signedB = 1'b0;
    case (bus.func3)
      3'b000, 3'b001, 3'b100, 3'b110: begin
        signedA = 1'b1;
        signedB = 1'b1;
      end
      3'b010:  signedA = 1'b1;
      default: ;
    endcase
  end

  assign negA      = signedA && bus.readData1[31];
  assign negB      = signedB && bus.readData2[31];
  assign absA      = negA ? (32'd0 - bus.readData1) : bus.readData1;
  assign absB      = negB ? (32'd0 - bus.readData2) : bus.readData2;
  assign divByZero = bus.func3[2] && (bus.readData2 == 32'd0);

  // One iteration step: accLo holds the multiplier (shifted out LSB first)
  // or the dividend (shifted out MSB first, quotient bits shifted in).
  assign mulSum     = {1'b0, accHi} + (accLo[0] ? {1'b0, operand} : 33'd0);
  assign divShifted = {accHi, accLo[31]};
  assign divDiff    = divShifted - {1'b0, operand};

  // State register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  // Next state; flush overrides any advance.
  always_comb begin
    stateNext = state;
    case (state)
      IDLE: begin
        if (issue) begin
          stateNext = (divByZero && FAST_DIV_BY_ZERO) ? DONE : BUSY;
        end
      end
      BUSY: begin
        if (counter == 5'd31) begin
          stateNext = DONE;
        end
      end
      default: stateNext = IDLE;
    endcase
    if (bus.flush) begin
      stateNext = IDLE;
    end
  end

  // Mul/div datapath. For a zero divisor signB is forced equal to signA, so
  // the all-ones quotient stays positive and the remainder regains the
  // dividend's sign; this gives the architectural result on both the fast
  // path and the iterated path with no extra special casing at the output.
  always_ff @(posedge clock) begin
    if (reset) begin
      counter <= '0;
      opFunc3 <= '0;
      operand <= '0;
      accHi   <= '0;
      accLo   <= '0;
      signA   <= 1'b0;
      signB   <= 1'b0;
    end else if (issue) begin
      counter <= '0;
      opFunc3 <= bus.func3;
      signA   <= negA;
      signB   <= divByZero ? negA : negB;
      if (bus.func3[2]) begin
        operand <= absB;
        if (divByZero && FAST_DIV_BY_ZERO) begin
          accHi <= absA;
          accLo <= '1;
        end else begin
          accHi <= '0;
          accLo <= absA;
        end
      end else begin
        operand <= absA;
        accHi   <= '0;
        accLo   <= absB;
      end
    end else if ((state == BUSY) && !bus.flush) begin
      counter <= counter + 5'd1;
      if (opFunc3[2]) begin
        accHi <= divDiff[32] ? divShifted[31:0] : divDiff[31:0];
        accLo <= {accLo[30:0], ~divDiff[32]};
      end else begin
        accHi <= mulSum[32:1];
        accLo <= {mulSum[0], accLo[31:1]};
      end
    end
  end

  // Sign correction of the finished magnitudes.
  always_comb begin
    product      = (signA ^ signB) ? (64'd0 - {accHi, accLo}) : {accHi, accLo};
    quotient     = (signA ^ signB) ? (32'd0 - accLo) : accLo;
    remainder    = signA ? (32'd0 - accHi) : accHi;
    mulDivResult = product[31:0];
    case (opFunc3)
      3'b000:                 mulDivResult = product[31:0];
      3'b001, 3'b010, 3'b011: mulDivResult = product[63:32];
      3'b100, 3'b101:         mulDivResult = quotient;
      default:                mulDivResult = remainder;
    endcase
  end

  // Outputs, all held at zero during reset. An M op that is not yet done
  // (or any M op when the unit is disabled) reads as 0.
  always_comb begin
    bus.aluResult    = '0;
    bus.storeData    = '0;
    bus.branchTarget = '0;
    bus.branchTaken  = 1'b0;
    bus.stall        = 1'b0;
    if (!reset) begin
      bus.storeData    = bus.readData2;
      bus.branchTarget = bus.pcAdderSrc
                         ? ((bus.readData1 + bus.immediateValue) & ~32'd1)
                         : (bus.pc + bus.immediateValue);
      bus.branchTaken  = bus.pcUpdate &&
                         ((bus.aluOperation == 3'b011) ? branchCond : 1'b1);
      bus.stall        = !bus.flush &&
                         ((state == BUSY) ||
                          ((state == IDLE) && isMOp && ENABLE_MULDIV));
      if (state == DONE) begin
        bus.aluResult = mulDivResult;
      end else if (!isMOp) begin
        bus.aluResult = aluValue;
      end
    end
  end

endmodule

// File: tb/tb_execute_stage_unit.sv
// Self-checking bench for execute_stage_unit: directed corner cases plus
// randomized ALU/branch and mul/div traffic checked against a reference model
// built from plain 64-bit arithmetic.
module tb_execute_stage_unit;

  logic clock;
  logic reset;
  int   checks;
  int   failures;

  execute_stage_unit_if bus ();

  execute_stage_unit #(
    .ENABLE_MULDIV    (1'b1),
    .FAST_DIV_BY_ZERO (1'b1)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Hard time limit so the run can never hang.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Drive every instruction field of the bus.
  task automatic applyStimulus(input logic [2:0] op, input logic [2:0] f3,
                               input logic [6:0] f7, input logic [1:0] s1,
                               input logic [1:0] s2, input logic [31:0] rs1,
                               input logic [31:0] rs2, input logic [31:0] imm,
                               input logic [31:0] pcv, input logic pcUpd,
                               input logic adderSrc);
    bus.aluOperation   = op;
    bus.func3          = f3;
    bus.func7          = f7;
    bus.aluSrc1        = s1;
    bus.aluSrc2        = s2;
    bus.readData1      = rs1;
    bus.readData2      = rs2;
    bus.immediateValue = imm;
    bus.pc             = pcv;
    bus.pcUpdate       = pcUpd;
    bus.pcAdderSrc     = adderSrc;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  task automatic nextCycle();
    @(posedge clock);
    #1;
  endtask

  // ---------------- reference model ----------------
  function automatic logic [31:0] refSrc1(input logic [1:0] s, input logic [31:0] rs1,
                                          input logic [31:0] pcv);
    if (s == 2'd0) return rs1;
    if (s == 2'd1) return pcv;
    return 32'd0;
  endfunction

  function automatic logic [31:0] refSrc2(input logic [1:0] s, input logic [31:0] rs2,
                                          input logic [31:0] imm);
    if (s == 2'd0) return rs2;
    if (s == 2'd1) return imm;
    return 32'd4;
  endfunction

  function automatic logic [31:0] refAlu(input logic [2:0] op, input logic [2:0] f3,
                                         input logic [6:0] f7, input logic [31:0] a,
                                         input logic [31:0] b);
    longint sa;
    longint sb;
    int     sh;
    sa = $signed(a);
    sb = $signed(b);
    sh = int'(b % 32);
    if (op == 3'b100) return b;
    if (op != 3'b001 && op != 3'b010) return a + b;
    case (f3)
      3'd0: return (op == 3'b001 && f7[5]) ? a - b : a + b;
      3'd1: return a << sh;
      3'd2: return (sa < sb) ? 32'd1 : 32'd0;
      3'd3: return (a < b) ? 32'd1 : 32'd0;
      3'd4: return a ^ b;
      3'd5: return f7[5] ? 32'(sa / (64'sd1 <<< sh) - ((sa < 0 && (sa % (64'sd1 <<< sh)) != 0) ? 1 : 0))
                         : a / (32'd1 << sh);
      3'd6: return a | b;
      default: return a & b;
    endcase
  endfunction

  function automatic logic refBranch(input logic [2:0] f3, input logic [31:0] a,
                                     input logic [31:0] b);
    longint sa;
    longint sb;
    sa = $signed(a);
    sb = $signed(b);
    case (f3)
      3'd0: return a == b;
      3'd1: return a != b;
      3'd4: return sa < sb;
      3'd5: return sa >= sb;
      3'd6: return a < b;
      3'd7: return a >= b;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] refMulDiv(input logic [2:0] f3, input logic [31:0] a,
                                            input logic [31:0] b);
    longint      sa;
    longint      sb;
    longint      ua;
    longint      ub;
    logic [63:0] p;
    sa = $signed(a);
    sb = $signed(b);
    ua = {32'd0, a};
    ub = {32'd0, b};
    case (f3)
      3'd0: begin p = sa * sb; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        p = sa / sb;
        return p[31:0];
      end
      3'd5: return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 32'd0) return a;
        p = sa % sb;
        return p[31:0];
      end
      default: return (b == 32'd0) ? a : a % b;
    endcase
  endfunction

  // Issue an M op at the current cycle, count stall cycles until the result
  // appears, check latency and value, then leave at the start of the cycle
  // after the result (where the next instruction may be presented).
  task automatic runMulDiv(input string tag, input logic [2:0] f3,
                           input logic [31:0] a, input logic [31:0] b,
                           input int expCycles);
    int cycles;
    applyStimulus(3'b001, f3, 7'b0000001, 2'b00, 2'b00, a, b, 32'h0, 32'h0, 1'b0, 1'b0);
    @(negedge clock);
    checkOutput({tag, "_issueStall"}, {31'b0, bus.stall}, 32'd1);
    cycles = 0;
    while (bus.stall === 1'b1 && cycles < 40) begin
      @(negedge clock);
      cycles++;
    end
    checkOutput({tag, "_latency"}, cycles, expCycles);
    checkOutput({tag, "_result"}, bus.aluResult, refMulDiv(f3, a, b));
    nextCycle();
  endtask

  logic [2:0]  rOp;
  logic [2:0]  rF3;
  logic [6:0]  rF7;
  logic [1:0]  rS1;
  logic [1:0]  rS2;
  logic [31:0] rRs1;
  logic [31:0] rRs2;
  logic [31:0] rImm;
  logic [31:0] rPc;
  logic        rPcUpd;
  logic        rAdder;
  logic [31:0] expTarget;
  logic        expTaken;

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b1;
    bus.flush = 1'b0;
    // M op and jump present during reset: every output must still read 0.
    applyStimulus(3'b001, 3'b000, 7'b0000001, 2'b00, 2'b00, 32'h1234_5678,
                  32'h0000_ABCD, 32'h10, 32'h200, 1'b1, 1'b0);
    @(negedge clock);
    checkOutput("reset_aluResult", bus.aluResult, 32'd0);
    checkOutput("reset_storeData", bus.storeData, 32'd0);
    checkOutput("reset_branchTarget", bus.branchTarget, 32'd0);
    checkOutput("reset_branchTaken", {31'b0, bus.branchTaken}, 32'd0);
    checkOutput("reset_stall", {31'b0, bus.stall}, 32'd0);
    nextCycle();
    reset = 1'b0;

    // SUB 5 - 7.
    applyStimulus(3'b001, 3'b000, 7'b0100000, 2'b00, 2'b00, 32'd5, 32'd7, 32'd0, 32'd0, 1'b0, 1'b0);
    @(negedge clock);
    checkOutput("sub_result", bus.aluResult, 32'hFFFF_FFFE);
    checkOutput("sub_stall", {31'b0, bus.stall}, 32'd0);
    checkOutput("sub_storeData", bus.storeData, 32'd7);
    nextCycle();

    // BLT then BLTU with the same operands.
    applyStimulus(3'b011, 3'b100, 7'd0, 2'b00, 2'b00, 32'hFFFF_FFFF, 32'd1, 32'h20, 32'h100, 1'b1, 1'b0);
    @(negedge clock);
    checkOutput("blt_taken", {31'b0, bus.branchTaken}, 32'd1);
    checkOutput("blt_target", bus.branchTarget, 32'h120);
    nextCycle();
    applyStimulus(3'b011, 3'b110, 7'd0, 2'b00, 2'b00, 32'hFFFF_FFFF, 32'd1, 32'h20, 32'h100, 1'b1, 1'b0);
    @(negedge clock);
    checkOutput("bltu_taken", {31'b0, bus.branchTaken}, 32'd0);
    nextCycle();

    // JALR with link address pc+4.
    applyStimulus(3'b000, 3'b000, 7'd0, 2'b01, 2'b10, 32'h1003, 32'd0, 32'd0, 32'h400, 1'b1, 1'b1);
    @(negedge clock);
    checkOutput("jalr_target", bus.branchTarget, 32'h1002);
    checkOutput("jalr_taken", {31'b0, bus.branchTaken}, 32'd1);
    checkOutput("jalr_link", bus.aluResult, 32'h404);
    nextCycle();

    // SRAI vs SRLI by func7[5]; ADDI ignores func7[5].
    applyStimulus(3'b010, 3'b101, 7'b0100000, 2'b00, 2'b01, 32'h8000_0000, 32'd0, 32'd4, 32'd0, 1'b0, 1'b0);
    @(negedge clock);
    checkOutput("srai_result", bus.aluResult, 32'hF800_0000);
    nextCycle();
    applyStimulus(3'b010, 3'b000, 7'b0100000, 2'b00, 2'b01, 32'd10, 32'd0, 32'd3, 32'd0, 1'b0, 1'b0);
    @(negedge clock);
    checkOutput("addi_f7_result", bus.aluResult, 32'd13);
    nextCycle();

    // Randomized ALU, branch and jump traffic.
    for (int i = 0; i < 60; i++) begin
      rOp    = 3'($urandom_range(0, 7));
      rF3    = 3'($urandom);
      rF7    = ($urandom_range(0, 1) == 1) ? 7'b0100000 : 7'b0000000;
      rS1    = (rOp == 3'b011) ? 2'b00 : 2'($urandom);
      rS2    = (rOp == 3'b011) ? 2'b00 : 2'($urandom);
      rRs1   = $urandom;
      rRs2   = ($urandom_range(0, 3) == 0) ? rRs1 : $urandom;
      rImm   = $urandom;
      rPc    = $urandom;
      rPcUpd = 1'($urandom);
      rAdder = 1'($urandom);
      applyStimulus(rOp, rF3, rF7, rS1, rS2, rRs1, rRs2, rImm, rPc, rPcUpd, rAdder);
      expTarget = rAdder ? ((rRs1 + rImm) & 32'hFFFF_FFFE) : (rPc + rImm);
      expTaken  = rPcUpd && ((rOp == 3'b011) ?
                  refBranch(rF3, refSrc1(rS1, rRs1, rPc), refSrc2(rS2, rRs2, rImm)) : 1'b1);
      @(negedge clock);
      if (rOp != 3'b011) begin
        checkOutput("rand_aluResult", bus.aluResult,
                    refAlu(rOp, rF3, rF7, refSrc1(rS1, rRs1, rPc), refSrc2(rS2, rRs2, rImm)));
      end
      checkOutput("rand_branchTaken", {31'b0, bus.branchTaken}, {31'b0, expTaken});
      checkOutput("rand_branchTarget", bus.branchTarget, expTarget);
      checkOutput("rand_storeData", bus.storeData, rRs2);
      checkOutput("rand_stall", {31'b0, bus.stall}, 32'd0);
      nextCycle();
    end

    // Directed mul/div corners; back-to-back issue also proves DONE -> IDLE.
    runMulDiv("mulh_min", 3'b001, 32'h8000_0000, 32'h8000_0000, 33);
    runMulDiv("div_ovf", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 33);
    runMulDiv("rem_ovf", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 33);
    runMulDiv("rem_zero", 3'b110, 32'd17, 32'd0, 1);
    runMulDiv("div_zero_neg", 3'b100, 32'hFFFF_FFF0, 32'd0, 1);
    runMulDiv("rem_zero_neg", 3'b110, 32'hFFFF_FFF0, 32'd0, 1);
    runMulDiv("divu_zero", 3'b101, 32'd99, 32'd0, 1);

    // Randomized mul/div.
    for (int i = 0; i < 10; i++) begin
      rF3  = 3'($urandom);
      rRs1 = $urandom;
      rRs2 = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
      runMulDiv("rand_muldiv", rF3, rRs1, rRs2, (rF3[2] && rRs2 == 32'd0) ? 1 : 33);
    end

    // Flush aborts a DIVU at T+10.
    applyStimulus(3'b001, 3'b101, 7'b0000001, 2'b00, 2'b00, 32'd1000, 32'd7, 32'd0, 32'd0, 1'b0, 1'b0);
    @(negedge clock);
    checkOutput("flush_issueStall", {31'b0, bus.stall}, 32'd1);
    for (int k = 1; k < 10; k++) begin
      nextCycle();
      @(negedge clock);
      checkOutput("flush_busyStall", {31'b0, bus.stall}, 32'd1);
    end
    nextCycle();
    bus.flush = 1'b1;
    @(negedge clock);
    checkOutput("flush_stallDrop", {31'b0, bus.stall}, 32'd0);
    nextCycle();
    bus.flush = 1'b0;
    runMulDiv("mul_after_flush", 3'b000, 32'd3, 32'd4, 33);

    // Reset in the middle of a MUL aborts it.
    applyStimulus(3'b001, 3'b000, 7'b0000001, 2'b00, 2'b00, 32'd9, 32'd9, 32'd0, 32'd0, 1'b0, 1'b0);
    for (int k = 0; k < 5; k++) nextCycle();
    reset = 1'b1;
    @(negedge clock);
    checkOutput("midreset_stall", {31'b0, bus.stall}, 32'd0);
    checkOutput("midreset_aluResult", bus.aluResult, 32'd0);
    nextCycle();
    reset = 1'b0;
    runMulDiv("mulhu_after_reset", 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33);

    // Plain op after an M result: no stall.
    applyStimulus(3'b000, 3'b000, 7'd0, 2'b00, 2'b00, 32'd1, 32'd2, 32'd0, 32'd0, 1'b0, 1'b0);
    @(negedge clock);
    checkOutput("idle_add_stall", {31'b0, bus.stall}, 32'd0);
    checkOutput("idle_add_result", bus.aluResult, 32'd3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
